sprite_layer_ctrl: RTL and testbench
====================================

# sprite_layer_ctrl

Per-pixel scheduler that shares one sprite-buffer lookup path between up to N_OBJ on-screen objects. It holds each object's position, size and integer scale, and accepts position/size updates from game logic through a ready/valid port. Updates are applied only at frame boundaries so no object tears mid-frame. For every VGA pixel it selects the highest-priority object covering that pixel and emits the object ID plus the linear pixel index into that object's colour buffers.

## Interface
Parameters:
- N_OBJ, 4 — number of objects; ID 0 has highest priority.
- CW, 10 — coordinate width (X/Y, width, height).
- IW, 11 — buffer index width (covers 40×40 = 1600 pixels).

Ports:
- CLK  in  1  — pixel clock.
- reset  in  1  — asynchronous, active-high.
- X_VGA  in  CW  — current beam X.
- Y_VGA  in  CW  — current beam Y.
- VGA_ACTIVE  in  1  — beam is in the visible area.
- FRAME_START  in  1  — one-cycle pulse at start of vertical blank.
- UPD_VALID  in  1  — an update is offered.
- UPD_READY  out  1  — an update can be accepted.
- UPD_ID  in  $clog2(N_OBJ)+1  — target object; values ≥ N_OBJ are legal and discarded.
- UPD_EN  in  1  — object visible.
- UPD_X, UPD_Y  in  CW  — top-left corner.
- UPD_LARGURA, UPD_ALTURA  in  CW  — unscaled width and height, in buffer pixels.
- UPD_SHIFT  in  2  — scale factor = 1 << UPD_SHIFT.
- HIT  out  1  — some object covers the pixel.
- HIT_ID  out  $clog2(N_OBJ)  — winning object.
- INDICE  out  IW  — linear index into the winner's buffer.

## Operation
- Each object has two register sets: shadow (written by updates) and active (used for rendering). Each object also has a pending bit.
- Update accept: UPD_VALID && UPD_READY. This writes that object's shadow set and sets its pending bit. A second update to the same ID within one frame overwrites the first; last write wins.
- UPD_READY = !FRAME_START. It is combinational, so an offer made in a FRAME_START cycle stalls one cycle.
- On FRAME_START, every object with its pending bit set copies shadow to active, and all pending bits clear. Active registers never change at any other time.
- Hit test for object i: en_i && X_i ≤ X_VGA < X_i + (LARG_i << s_i) && Y_i ≤ Y_VGA < Y_i + (ALT_i << s_i). Right and bottom bounds are exclusive.
- Bound sums are computed in CW+4 bits, so objects partially off-screen never wrap.
- Local offsets: dx = X_VGA − X_i, dy = Y_VGA − Y_i.
- Index: INDICE = (dy >> s_i) * LARG_i + (dx >> s_i), truncated to IW bits.
- Priority: the lowest set bit of the hit vector wins.
- When VGA_ACTIVE = 0, the hit vector is forced to 0.

## Timing
- Two-stage pipeline; X_VGA/Y_VGA/VGA_ACTIVE → outputs latency is 2 cycles.
  - Stage 1 registers the hit vector plus dx and dy for all objects.
  - Stage 2 registers the priority select, the multiply-add and the outputs.
- Reset values: HIT = 0, HIT_ID = 0, INDICE = 0.
- Reset clears all objects in both register sets to en = 0 and all fields 0, clears pending bits, and clears the pipeline.
- UPD_READY follows FRAME_START and is 1 during reset release.
- A commit at FRAME_START affects hit tests starting with the pixel sampled in the next cycle.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). Any pending updates are lost.

## Configuration
- SPRITE_LAYER_COLLISION_EN defined:
  - Adds output COLLISION_MASK [N_OBJ-1:0].
  - During a frame, each stage-1 cycle in which two or more hit bits are set ORs those bits into a sticky accumulator.
  - On FRAME_START, the accumulator is copied to COLLISION_MASK and then cleared.
  - COLLISION_MASK resets to 0.
- Macro undefined: no accumulator and no COLLISION_MASK port.

## Structure
- Package sprite_pkg contains:
  - the N_OBJ and CW defaults;
  - typedef obj_cfg_t {en, x, y, larg, alt, shift};
  - a helper function for the scaled bound.
- One sub-module: sprite_hit, instantiated N_OBJ times. It holds one object's hit comparator and dx/dy offset logic and produces stage-1 values.
- Priority encoder and multiply-add live in the top level.

## Test plan
- Reset then idle:
  - HIT = 0 over a full frame.
  - UPD_READY = 1 except during FRAME_START cycles.
- Single object: ID0, X=100, Y=50, 40×40, shift=0, then FRAME_START.
  - Pixel (100,50) → HIT=1, ID=0, INDICE=0 two cycles later.
  - (139,89) → 1599.
  - (140,50) → HIT=0.
- Scale: ID1, X=0, Y=0, LARG=10, shift=2.
  - Pixel (7,5) → INDICE = (5>>2)*10 + (7>>2) = 11.
  - (40,0) → no hit.
- Priority/overlap: ID0 and ID2 both cover (200,200) → HIT_ID=0.
  - With SPRITE_LAYER_COLLISION_EN, COLLISION_MASK = 4'b0101 after the next FRAME_START.
- Deferred commit:
  - Update ID0 X=300 mid-frame → rendering stays at the old X until FRAME_START.
  - Two updates before FRAME_START → the second value is used.
  - UPD_ID=7 → accepted, no effect.
- Handshake collision: UPD_VALID held through FRAME_START → READY low that cycle; the update is accepted next cycle and committed at the following FRAME_START.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite layer scheduler.
// Optional feature macro used by the top: SPRITE_LAYER_COLLISION_EN.
package sprite_pkg;

  localparam int N_OBJ_DEFAULT = 4;
  localparam int CW_DEFAULT    = 10;
  localparam int IW_DEFAULT    = 11;

  typedef struct packed {
    logic                  en;
    logic [CW_DEFAULT-1:0] x;
    logic [CW_DEFAULT-1:0] y;
    logic [CW_DEFAULT-1:0] larg;
    logic [CW_DEFAULT-1:0] alt;
    logic [1:0]            shift;
  } obj_cfg_t;

  // Exclusive far edge, widened so objects hanging past the screen never wrap.
  function automatic logic [CW_DEFAULT+3:0] scaled_bound(
    input logic [CW_DEFAULT-1:0] base,
    input logic [CW_DEFAULT-1:0] size,
    input logic [1:0]            shift
  );
    return {4'b0, base} + ({4'b0, size} << shift);
  endfunction

endpackage

// File: rtl/sprite_layer_ctrl_hit.sv
// Stage-1 slice for one object: coverage test and local offsets, registered.
// Unaffected by SPRITE_LAYER_COLLISION_EN.
module sprite_hit
  import sprite_pkg::*;
(
  input  logic                  CLK,
  input  logic                  reset,
  input  obj_cfg_t              cfg,
  input  logic [CW_DEFAULT-1:0] x_vga,
  input  logic [CW_DEFAULT-1:0] y_vga,
  input  logic                  vga_active,
  output logic                  hit,
  output logic [CW_DEFAULT-1:0] dx,
  output logic [CW_DEFAULT-1:0] dy,
  output logic [CW_DEFAULT-1:0] larg,
  output logic [1:0]            shift
);

  logic [CW_DEFAULT+3:0] x_end;
  logic [CW_DEFAULT+3:0] y_end;
  logic                  hit_c;

  assign x_end = scaled_bound(cfg.x, cfg.larg, cfg.shift);
  assign y_end = scaled_bound(cfg.y, cfg.alt, cfg.shift);

  assign hit_c = vga_active && cfg.en &&
                 (x_vga >= cfg.x) && ({4'b0, x_vga} < x_end) &&
                 (y_vga >= cfg.y) && ({4'b0, y_vga} < y_end);

  // Width and scale travel with the offsets so a commit between stages cannot mix configs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hit   <= 1'b0;
      dx    <= '0;
      dy    <= '0;
      larg  <= '0;
      shift <= '0;
    end else begin
      hit   <= hit_c;
      dx    <= x_vga - cfg.x;
      dy    <= y_vga - cfg.y;
      larg  <= cfg.larg;
      shift <= cfg.shift;
    end
  end

endmodule

// File: rtl/sprite_layer_ctrl.sv
// Per-pixel object scheduler with frame-synchronous config commit.
// Define SPRITE_LAYER_COLLISION_EN to add the per-frame COLLISION_MASK output.
module sprite_layer_ctrl
  import sprite_pkg::*;
#(
  parameter int N_OBJ = N_OBJ_DEFAULT,
  parameter int CW    = CW_DEFAULT,
  parameter int IW    = IW_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [CW-1:0]            X_VGA,
  input  logic [CW-1:0]            Y_VGA,
  input  logic                     VGA_ACTIVE,
  input  logic                     FRAME_START,
  input  logic                     UPD_VALID,
  output logic                     UPD_READY,
  input  logic [$clog2(N_OBJ):0]   UPD_ID,
  input  logic                     UPD_EN,
  input  logic [CW-1:0]            UPD_X,
  input  logic [CW-1:0]            UPD_Y,
  input  logic [CW-1:0]            UPD_LARGURA,
  input  logic [CW-1:0]            UPD_ALTURA,
  input  logic [1:0]               UPD_SHIFT,
`ifdef SPRITE_LAYER_COLLISION_EN
  output logic [N_OBJ-1:0]         COLLISION_MASK,
`endif
  output logic                     HIT,
  output logic [$clog2(N_OBJ)-1:0] HIT_ID,
  output logic [IW-1:0]            INDICE
);

  localparam int IDW  = $clog2(N_OBJ);
  localparam int UIDW = IDW + 1;

  obj_cfg_t             shadow [N_OBJ];
  obj_cfg_t             active [N_OBJ];
  logic [N_OBJ-1:0]     pending;

  logic [N_OBJ-1:0]     hit_vec;
  logic [CW-1:0]        dx_s1    [N_OBJ];
  logic [CW-1:0]        dy_s1    [N_OBJ];
  logic [CW-1:0]        larg_s1  [N_OBJ];
  logic [1:0]           shift_s1 [N_OBJ];

  logic [IDW-1:0]       win_id;
  logic [CW-1:0]        sel_dx;
  logic [CW-1:0]        sel_dy;
  logic [CW-1:0]        sel_larg;
  logic [1:0]           sel_shift;
  logic [2*CW-1:0]      prod;
  logic [IW-1:0]        idx_c;

  assign UPD_READY = !FRAME_START;

  // Updates land in shadow; only FRAME_START promotes pending shadows to active.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OBJ; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pending <= '0;
    end else if (FRAME_START) begin
      for (int i = 0; i < N_OBJ; i++) begin
        if (pending[i]) active[i] <= shadow[i];
      end
      pending <= '0;
    end else if (UPD_VALID && (UPD_ID < UIDW'(N_OBJ))) begin
      shadow[UPD_ID[IDW-1:0]]  <= '{en: UPD_EN, x: UPD_X, y: UPD_Y, larg: UPD_LARGURA,
                                    alt: UPD_ALTURA, shift: UPD_SHIFT};
      pending[UPD_ID[IDW-1:0]] <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    sprite_hit u_hit (
      .CLK        (CLK),
      .reset      (reset),
      .cfg        (active[g]),
      .x_vga      (X_VGA),
      .y_vga      (Y_VGA),
      .vga_active (VGA_ACTIVE),
      .hit        (hit_vec[g]),
      .dx         (dx_s1[g]),
      .dy         (dy_s1[g]),
      .larg       (larg_s1[g]),
      .shift      (shift_s1[g])
    );
  end

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    win_id = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit_vec[i]) win_id = IDW'(i);
    end
  end

  assign sel_dx    = dx_s1[win_id];
  assign sel_dy    = dy_s1[win_id];
  assign sel_larg  = larg_s1[win_id];
  assign sel_shift = shift_s1[win_id];
  assign prod      = (2*CW)'(sel_dy >> sel_shift) * (2*CW)'(sel_larg);
  assign idx_c     = IW'(prod + (2*CW)'(sel_dx >> sel_shift));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      HIT    <= 1'b0;
      HIT_ID <= '0;
      INDICE <= '0;
    end else begin
      HIT    <= |hit_vec;
      HIT_ID <= win_id;
      INDICE <= (|hit_vec) ? idx_c : '0;
    end
  end

`ifdef SPRITE_LAYER_COLLISION_EN
  logic [N_OBJ-1:0] coll_acc;
  logic             multi_hit;

  assign multi_hit = (hit_vec & (hit_vec - 1'b1)) != '0;

  // Overlaps accumulate across the frame and are published at the next boundary.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      coll_acc       <= '0;
      COLLISION_MASK <= '0;
    end else if (FRAME_START) begin
      COLLISION_MASK <= coll_acc;
      coll_acc       <= '0;
    end else if (multi_hit) begin
      coll_acc <= coll_acc | hit_vec;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_layer_ctrl.sv
// Self-checking bench for sprite_layer_ctrl: directed scenarios plus random traffic vs a model.
// Also checks COLLISION_MASK when built with SPRITE_LAYER_COLLISION_EN.
module tb_sprite_layer_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic [9:0]  X_VGA, Y_VGA;
  logic        VGA_ACTIVE, FRAME_START, UPD_VALID, UPD_READY;
  logic [2:0]  UPD_ID;
  logic        UPD_EN;
  logic [9:0]  UPD_X, UPD_Y, UPD_LARGURA, UPD_ALTURA;
  logic [1:0]  UPD_SHIFT;
  logic        HIT;
  logic [1:0]  HIT_ID;
  logic [10:0] INDICE;
`ifdef SPRITE_LAYER_COLLISION_EN
  logic [3:0]  COLLISION_MASK;
`endif

  int checks = 0;
  int errors = 0;

  sprite_layer_ctrl dut (
    .CLK         (CLK),
    .reset       (reset),
    .X_VGA       (X_VGA),
    .Y_VGA       (Y_VGA),
    .VGA_ACTIVE  (VGA_ACTIVE),
    .FRAME_START (FRAME_START),
    .UPD_VALID   (UPD_VALID),
    .UPD_READY   (UPD_READY),
    .UPD_ID      (UPD_ID),
    .UPD_EN      (UPD_EN),
    .UPD_X       (UPD_X),
    .UPD_Y       (UPD_Y),
    .UPD_LARGURA (UPD_LARGURA),
    .UPD_ALTURA  (UPD_ALTURA),
    .UPD_SHIFT   (UPD_SHIFT),
`ifdef SPRITE_LAYER_COLLISION_EN
    .COLLISION_MASK (COLLISION_MASK),
`endif
    .HIT         (HIT),
    .HIT_ID      (HIT_ID),
    .INDICE      (INDICE)
  );

  always #5 CLK = ~CLK;

  // Reference state: what the game has written, what the renderer uses, and the 2-deep output delay.
  int a_en[4], a_x[4], a_y[4], a_l[4], a_a[4], a_s[4];
  int s_en[4], s_x[4], s_y[4], s_l[4], s_a[4], s_s[4];
  bit pend[4];
  bit e1_hit, e2_hit;
  int e1_id, e2_id, e1_idx, e2_idx;
  bit [3:0] m_hv1, m_acc, m_mask;

  function automatic bit [3:0] model_hits(int px, int py, bit act);
    bit [3:0] v = '0;
    for (int i = 0; i < 4; i++) begin
      if (act && a_en[i] != 0 &&
          px >= a_x[i] && px < a_x[i] + (a_l[i] << a_s[i]) &&
          py >= a_y[i] && py < a_y[i] + (a_a[i] << a_s[i]))
        v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic int popcount4(bit [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        a_en[i] = 0; a_x[i] = 0; a_y[i] = 0; a_l[i] = 0; a_a[i] = 0; a_s[i] = 0;
        s_en[i] = 0; s_x[i] = 0; s_y[i] = 0; s_l[i] = 0; s_a[i] = 0; s_s[i] = 0;
        pend[i] = 0;
      end
      e1_hit = 0; e2_hit = 0; e1_id = 0; e2_id = 0; e1_idx = 0; e2_idx = 0;
      m_hv1 = '0; m_acc = '0; m_mask = '0;
    end else begin
      bit [3:0] hv;
      int w, px, py;
      px = int'(X_VGA); py = int'(Y_VGA);
      hv = model_hits(px, py, VGA_ACTIVE);
      w = 0;
      for (int i = 3; i >= 0; i--) if (hv[i]) w = i;
      e2_hit = e1_hit; e2_id = e1_id; e2_idx = e1_idx;
      e1_hit = (hv != 0);
      e1_id  = w;
      e1_idx = (hv != 0) ? ((((py - a_y[w]) >> a_s[w]) * a_l[w] + ((px - a_x[w]) >> a_s[w])) % 2048) : 0;
      if (FRAME_START) begin
        m_mask = m_acc; m_acc = '0;
      end else if (popcount4(m_hv1) >= 2) begin
        m_acc = m_acc | m_hv1;
      end
      m_hv1 = hv;
      if (FRAME_START) begin
        for (int i = 0; i < 4; i++) begin
          if (pend[i]) begin
            a_en[i] = s_en[i]; a_x[i] = s_x[i]; a_y[i] = s_y[i];
            a_l[i] = s_l[i]; a_a[i] = s_a[i]; a_s[i] = s_s[i];
          end
          pend[i] = 0;
        end
      end else if (UPD_VALID && UPD_ID < 3'd4) begin
        int k;
        k = int'(UPD_ID);
        s_en[k] = int'(UPD_EN); s_x[k] = int'(UPD_X); s_y[k] = int'(UPD_Y);
        s_l[k] = int'(UPD_LARGURA); s_a[k] = int'(UPD_ALTURA); s_s[k] = int'(UPD_SHIFT);
        pend[k] = 1;
      end
    end
  end

  task automatic check_output(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the reference, away from the rising edge.
  always @(negedge CLK) begin
    if (reset) begin
      check_output("reset_hit", int'(HIT), 0);
      check_output("reset_indice", int'(INDICE), 0);
    end else begin
      check_output("cmp_ready", int'(UPD_READY), int'(!FRAME_START));
      check_output("cmp_hit", int'(HIT), int'(e2_hit));
      if (e2_hit) begin
        check_output("cmp_hit_id", int'(HIT_ID), e2_id);
        check_output("cmp_indice", int'(INDICE), e2_idx);
      end
`ifdef SPRITE_LAYER_COLLISION_EN
      check_output("cmp_collision", int'(COLLISION_MASK), int'(m_mask));
`endif
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic apply_stimulus(int id, int en, int x, int y, int l, int a, int s);
    UPD_ID = 3'(id); UPD_EN = 1'(en); UPD_X = 10'(x); UPD_Y = 10'(y);
    UPD_LARGURA = 10'(l); UPD_ALTURA = 10'(a); UPD_SHIFT = 2'(s);
    UPD_VALID = 1'b1;
    tick(1);
    UPD_VALID = 1'b0;
  endtask

  task automatic frame_pulse();
    FRAME_START = 1'b1;
    tick(1);
    FRAME_START = 1'b0;
  endtask

  task automatic probe(string name, int x, int y, int hit, int id, int idx);
    X_VGA = 10'(x); Y_VGA = 10'(y); VGA_ACTIVE = 1'b1;
    tick(2);
    check_output({name, "_hit"}, int'(HIT), hit);
    if (hit != 0) begin
      check_output({name, "_id"}, int'(HIT_ID), id);
      check_output({name, "_idx"}, int'(INDICE), idx);
    end
  endtask

  initial begin
    reset = 1'b1;
    X_VGA = '0; Y_VGA = '0; VGA_ACTIVE = 1'b0; FRAME_START = 1'b0; UPD_VALID = 1'b0;
    UPD_ID = '0; UPD_EN = 1'b0; UPD_X = '0; UPD_Y = '0;
    UPD_LARGURA = '0; UPD_ALTURA = '0; UPD_SHIFT = '0;
    #3;
    check_output("ready_in_reset", int'(UPD_READY), 1);
    check_output("reset_hit_id", int'(HIT_ID), 0);
    #20;
    reset = 1'b0;
    tick(1);

    // Idle frame with no objects: never a hit.
    for (int c = 0; c < 150; c++) begin
      X_VGA = 10'($urandom_range(0, 1023));
      Y_VGA = 10'($urandom_range(0, 1023));
      VGA_ACTIVE = 1'($urandom_range(0, 1));
      FRAME_START = (c == 100);
      tick(1);
    end
    FRAME_START = 1'b0;

    apply_stimulus(0, 1, 100, 50, 40, 40, 0);
    frame_pulse();
    probe("single_origin", 100, 50, 1, 0, 0);
    probe("single_corner", 139, 89, 1, 0, 1599);
    probe("single_right_edge", 140, 50, 0, 0, 0);

    apply_stimulus(1, 1, 0, 0, 10, 10, 2);
    frame_pulse();
    probe("scale_inside", 7, 5, 1, 1, 11);
    probe("scale_edge", 40, 0, 0, 0, 0);

    apply_stimulus(0, 1, 300, 50, 40, 40, 0);
    probe("deferred_old", 100, 50, 1, 0, 0);
    probe("deferred_new_early", 300, 50, 0, 0, 0);
    apply_stimulus(0, 1, 320, 50, 40, 40, 0);
    apply_stimulus(7, 1, 100, 50, 40, 40, 0);
    frame_pulse();
    probe("last_write_wins", 320, 50, 1, 0, 0);
    probe("first_write_gone", 300, 50, 0, 0, 0);
    probe("id7_ignored", 100, 50, 0, 0, 0);

    apply_stimulus(0, 1, 190, 190, 40, 40, 0);
    apply_stimulus(2, 1, 180, 180, 30, 30, 0);
    frame_pulse();
    probe("overlap_priority", 200, 200, 1, 0, 410);
    probe("overlap_low_only", 185, 185, 1, 2, 155);
    frame_pulse();
`ifdef SPRITE_LAYER_COLLISION_EN
    check_output("collision_mask", int'(COLLISION_MASK), 5);
`endif

    // Offer held across a frame boundary: stalled, then taken, then committed a frame later.
    UPD_ID = 3'd3; UPD_EN = 1'b1; UPD_X = 10'd500; UPD_Y = 10'd400;
    UPD_LARGURA = 10'd8; UPD_ALTURA = 10'd8; UPD_SHIFT = 2'd1;
    UPD_VALID = 1'b1; FRAME_START = 1'b1;
    #1;
    check_output("ready_low_at_frame", int'(UPD_READY), 0);
    tick(1);
    FRAME_START = 1'b0;
    #1;
    check_output("ready_high_after", int'(UPD_READY), 1);
    tick(1);
    UPD_VALID = 1'b0;
    probe("handshake_pending", 503, 401, 0, 0, 0);
    frame_pulse();
    probe("handshake_commit", 503, 401, 1, 3, 1);

    // Asynchronous reset while an object is being hit.
    reset = 1'b1;
    #1;
    check_output("async_reset_hit", int'(HIT), 0);
    check_output("async_reset_id", int'(HIT_ID), 0);
    tick(2);
    reset = 1'b0;
    probe("after_reset_cleared", 503, 401, 0, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      FRAME_START = ($urandom_range(0, 59) == 0);
      UPD_VALID   = ($urandom_range(0, 3) == 0);
      UPD_ID      = 3'($urandom_range(0, 7));
      UPD_EN      = ($urandom_range(0, 4) != 0);
      UPD_X       = 10'($urandom_range(0, 1023));
      UPD_Y       = 10'($urandom_range(0, 1023));
      UPD_LARGURA = 10'($urandom_range(0, 40));
      UPD_ALTURA  = 10'($urandom_range(0, 40));
      UPD_SHIFT   = 2'($urandom_range(0, 3));
      X_VGA       = 10'($urandom_range(0, 1023));
      Y_VGA       = 10'($urandom_range(0, 1023));
      VGA_ACTIVE  = ($urandom_range(0, 7) != 0);
      tick(1);
    end
    FRAME_START = 1'b0;
    UPD_VALID = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
